// File: rtl/binario_para_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  // Nibble that the seven-segment decoders render as a dark digit.
  localparam logic [3:0] BCD_APAGADO = 4'hF;

  // Smallest digit count whose decimal range covers every WIDTH-bit value,
  // i.e. the smallest D with 10^D >= 2^WIDTH.
  function automatic int min_digitos(input int largura);
    longint unsigned v_lim;
    longint unsigned v_pot;
    int              v_d;
    v_lim = longint'(1) << largura;
    v_pot = 1;
    v_d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (v_pot < v_lim) begin
        v_pot = v_pot * 10;
        v_d   = v_d + 1;
      end
    end
    if (v_d < 1) v_d = 1;
    return v_d;
  endfunction

endpackage

// File: rtl/binario_para_bcd_if.sv
// Start/result handshake between a requester and the converter.
interface binario_para_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  iniciar;
  logic [WIDTH-1:0]      entrada;
  logic                  ocupado;
  logic                  pronto;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output iniciar, entrada, input ocupado, pronto, bcd);
  modport slave  (input iniciar, entrada, output ocupado, pronto, bcd);
endinterface

// File: rtl/binario_para_bcd_ajuste.sv
// One double-dabble correction cell: digits of 5 or more get 3 added so the
// following left shift carries into the next decimal digit.
module ajuste_bcd (
  input  logic [3:0] i_digito,
  output logic [3:0] o_digito
);
  assign o_digito = (i_digito >= 4'd5) ? (i_digito + 4'd3) : i_digito;
endmodule

// File: rtl/binario_para_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, with optional
// leading-zero blanking of the presented digits.
module binario_para_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int BLANK_ZEROS = 1
) (
  input  logic             clock,
  input  logic             reset,
  binario_para_bcd_if.slave bus
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam int              BW        = 4 * DIGITS;
  localparam logic [CW-1:0]   CARGA     = CW'(WIDTH);
  localparam logic [BW-1:0]   BCD_RESET = (BLANK_ZEROS != 0) ?
                                          {{(DIGITS-1){BCD_APAGADO}}, 4'h0} : '0;

  if (DIGITS < min_digitos(WIDTH)) begin : g_erro_digitos
    $error("binario_para_bcd: DIGITS too small for WIDTH");
  end

  estado_t         r_estado;
  logic [CW-1:0]   r_cont;
  logic [BW-1:0]   r_acum;
  logic [WIDTH-1:0] r_desloc;
  logic [BW-1:0]   r_bcd;
  logic            r_ocupado;
  logic            r_pronto;

  logic [BW-1:0]   w_ajustado;
  logic [BW-1:0]   w_apagado;

  for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .i_digito (r_acum[4*g +: 4]),
      .o_digito (w_ajustado[4*g +: 4])
    );
  end

  // Leading-zero blanking of the finished accumulator; the units digit always shows.
  always_comb begin : p_apaga
    logic v_lider;
    w_apagado = r_acum;
    v_lider   = 1'b1;
    if (BLANK_ZEROS != 0) begin
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (v_lider && (r_acum[4*k +: 4] == 4'h0)) begin
          w_apagado[4*k +: 4] = BCD_APAGADO;
        end else begin
          v_lider = 1'b0;
        end
      end
    end
  end

  // Conversion FSM with registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_cont    <= '0;
      r_acum    <= '0;
      r_desloc  <= '0;
      r_bcd     <= BCD_RESET;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            r_desloc  <= bus.entrada;
            r_acum    <= '0;
            r_cont    <= CARGA;
            r_ocupado <= 1'b1;
            r_estado  <= DESLOCA;
          end
        end
        DESLOCA: begin
          r_acum   <= {w_ajustado[BW-2:0], r_desloc[WIDTH-1]};
          r_desloc <= {r_desloc[WIDTH-2:0], 1'b0};
          r_cont   <= r_cont - 1'b1;
          if (r_cont == CW'(1)) r_estado <= FIM;
        end
        FIM: begin
          r_bcd     <= w_apagado;
          r_pronto  <= 1'b1;
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign bus.ocupado = r_ocupado;
  assign bus.pronto  = r_pronto;
  assign bus.bcd     = r_bcd;

endmodule

// File: tb/tb_binario_para_bcd.sv
// Bench for binario_para_bcd: decimal reference model plus directed vectors.
module tb_binario_para_bcd;

  localparam int W = 16;
  localparam int D = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  binario_para_bcd_if #(.WIDTH(W), .DIGITS(D)) bus  ();
  binario_para_bcd_if #(.WIDTH(W), .DIGITS(D)) bus2 ();

  binario_para_bcd #(.WIDTH(W), .DIGITS(D), .BLANK_ZEROS(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  binario_para_bcd #(.WIDTH(W), .DIGITS(D), .BLANK_ZEROS(0)) dut_nb (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int prontos = 0;
  bit chk_en = 0;

  int          m_rem = 0;
  int unsigned m_val = 0;
  logic        m_oc = 1'b0;
  logic        m_pr = 1'b0;
  logic [19:0] m_bcd = 20'hFFFF0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Decimal digits of v, digits beyond its decimal length shown dark.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    int unsigned p;
    int          nd;
    nd = 1;
    x  = v / 10;
    while (x > 0) begin
      nd++;
      x = x / 10;
    end
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = (i < nd) ? 4'((v / p) % 10) : 4'hF;
      p = p * 10;
    end
    return r;
  endfunction

  // Reference timing: accept in idle, result W+1 edges later, then idle again.
  always @(posedge clock) begin
    if (reset) begin
      m_rem <= 0;
      m_oc  <= 1'b0;
      m_pr  <= 1'b0;
      m_bcd <= 20'hFFFF0;
    end else begin
      m_pr <= 1'b0;
      if (m_rem == 0) begin
        if (bus.iniciar === 1'b1) begin
          m_val   <= bus.entrada;
          m_rem   <= W + 1;
          m_oc    <= 1'b1;
          accepts <= accepts + 1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_bcd <= ref_bcd(m_val);
          m_pr  <= 1'b1;
          m_oc  <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("ocupado", bus.ocupado, m_oc);
      check("pronto", bus.pronto, m_pr);
      check("bcd", bus.bcd, m_bcd);
      if (bus.pronto === 1'b1) prontos <= prontos + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pronto(output int n);
    n = 0;
    while (bus.pronto !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("pronto_seen", bus.pronto, 1'b1);
  endtask

  task automatic run(input int unsigned v, output int n);
    bus.entrada = W'(v);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    wait_pronto(n);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int a0, p0, nsweep;
    bus.iniciar  = 1'b0;
    bus.entrada  = '0;
    bus2.iniciar = 1'b0;
    bus2.entrada = '0;

    reset = 1'b1;
    repeat (3) tick();
    chk_en = 1;
    check("rst_bcd", bus.bcd, 20'hFFFF0);
    check("rst_bcd_nb", bus2.bcd, 20'h00000);
    check("rst_ocupado", bus.ocupado, 1'b0);
    check("rst_pronto", bus.pronto, 1'b0);
    check("model_rst", m_bcd, 20'hFFFF0);
    reset = 1'b0;
    tick();

    run(1234, n);
    check("lat_1234", n, 17);
    check("bcd_1234", bus.bcd, 20'hF1234);
    check("model_1234", m_bcd, 20'hF1234);
    tick();
    run(0, n);
    check("bcd_0", bus.bcd, 20'hFFFF0);
    tick();
    run(65535, n);
    check("bcd_65535", bus.bcd, 20'h65535);
    check("model_65535", m_bcd, 20'h65535);
    tick();

    bus2.entrada = 16'd7;
    bus2.iniciar = 1'b1;
    tick();
    bus2.iniciar = 1'b0;
    n = 0;
    while (bus2.pronto !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("lat_nb", n, 17);
    check("bcd_nb_7", bus2.bcd, 20'h00007);
    tick();

    bus.entrada = 16'd40000;
    bus.iniciar = 1'b1;
    tick();
    repeat (5) tick();
    bus.entrada = 16'd999;
    wait_pronto(n);
    check("lat_hold", n, 12);
    check("bcd_40000", bus.bcd, 20'h40000);
    tick();
    bus.iniciar = 1'b0;
    wait_pronto(n);
    check("lat_b2b", n, 17);
    check("bcd_999", bus.bcd, 20'hFF999);
    tick();

    p0 = prontos;
    bus.entrada = 16'd50000;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("midrst_ocupado", bus.ocupado, 1'b0);
    check("midrst_bcd", bus.bcd, 20'hFFFF0);
    check("midrst_pronto", bus.pronto, 1'b0);
    reset = 1'b0;
    repeat (25) tick();
    check("midrst_no_pronto", prontos, p0);
    run(50000, n);
    check("bcd_50000", bus.bcd, 20'h50000);
    tick();

    reset = 1'b1;
    bus.iniciar = 1'b1;
    bus.entrada = 16'd5;
    tick();
    check("rst_vs_start", bus.ocupado, 1'b0);
    reset = 1'b0;
    bus.iniciar = 1'b0;
    tick();
    check("rst_vs_start_after", bus.ocupado, 1'b0);
    tick();

    a0 = accepts;
    p0 = prontos;
    nsweep = 0;
    for (int v = 0; v < 1100; v++) begin
      run(v, n);
      nsweep++;
    end
    for (int i = 0; i < 1400; i++) begin
      run(1100 + i * 46, n);
      nsweep++;
    end
    run(65535, n);
    nsweep++;
    tick();
    tick();
    check("sweep_accepts", accepts - a0, nsweep);
    check("sweep_prontos", prontos - p0, accepts - a0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
